// File: rtl/sim_harness_ctrl.sv
// sim_harness_ctrl: run controller that sequences DUT reset, paces dut_ready, gathers core halts and runs a watchdog
// Ports:
//   clock        - single clock, all state on posedge
//   reset        - synchronous active-low controller reset
//   io_halt      - per-core halt levels, sampled every RUN cycle
//   dut_reset    - active-high reset to the DUT, held during HOLD
//   dut_ready    - ready/enable to the DUT in the selected stall pattern
//   finish       - one-cycle pulse when the run ends (completion or timeout)
//   done         - sticky, run completed normally
//   timed_out    - sticky, watchdog expired
//   cycle_count  - saturating count of RUN cycles
//   halt_mask    - sticky record of halted cores
module sim_harness_ctrl #(
  parameter int          NUM_CORES    = 1,
  parameter int          RESET_CYCLES = 2,
  parameter int          CNT_W        = 32,
  parameter int          TIMEOUT      = 0,
  parameter int          STALL_MODE   = 0,
  parameter int          STALL_PERIOD = 4,
  parameter int          HALT_ALL     = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] io_halt,
  output logic                 dut_reset,
  output logic                 dut_ready,
  output logic                 finish,
  output logic                 done,
  output logic                 timed_out,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [NUM_CORES-1:0] halt_mask
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int PW = $clog2(STALL_PERIOD);
  localparam logic [15:0] SEED = LFSR_SEED == 16'd0 ? 16'hACE1 : LFSR_SEED;
  typedef enum logic [1:0] {HOLD, RUN, DONE, TOUT} state_e;
  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CORES-1:0] mask_q, mask_d, m;
  logic                 dutrst_q, dutrst_d, rdy_q, rdy_d, fin_q, fin_d;
  logic                 done_q, done_d, to_q, to_d;
  logic                 run, cmpl, expire;
  // the halt arriving this cycle counts toward completion alongside earlier ones
  assign m      = mask_q | io_halt;
  assign run    = state_q == RUN;
  assign cmpl   = HALT_ALL != 0 ? &m : |m;
  // cnt_q still holds the previous count, so the TIMEOUT-th cycle sees TIMEOUT-1
  assign expire = TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      phase_q  <= '0;
      lfsr_q   <= SEED;
      cnt_q    <= '0;
      mask_q   <= '0;
      dutrst_q <= 1'b1;
      rdy_q    <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      dutrst_q <= dutrst_d;
      rdy_q    <= rdy_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
      to_q     <= to_d;
    end
  end
  // completion takes priority over the watchdog on the same cycle
  always_comb begin
    state_d = state_q == HOLD ? (hold_q == HW'(RESET_CYCLES - 1) ? RUN : HOLD) :
              run             ? (cmpl ? DONE : expire ? TOUT : RUN) : state_q;
  end
  // outputs are computed for the next cycle and registered, so they key off state_d
  always_comb begin
    hold_d   = state_q == HOLD ? hold_q + 1'b1 : hold_q;
    cnt_d    = run && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    mask_d   = run ? m : mask_q;
    phase_d  = !run ? phase_q : phase_q == PW'(STALL_PERIOD - 1) ? '0 : phase_q + 1'b1;
    lfsr_d   = !run ? lfsr_q : (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    dutrst_d = state_d == HOLD;
    rdy_d    = state_d == RUN && (STALL_MODE == 1 ? phase_d != PW'(STALL_PERIOD - 1) :
                                  STALL_MODE == 2 ? lfsr_d[0] : 1'b1);
    fin_d    = run && state_d != RUN;
    done_d   = done_q | (run && cmpl);
    to_d     = to_q | (run && !cmpl && expire);
  end
  assign dut_reset   = dutrst_q;
  assign dut_ready   = rdy_q;
  assign finish      = fin_q;
  assign done        = done_q;
  assign timed_out   = to_q;
  assign cycle_count = cnt_q;
  assign halt_mask   = mask_q;
endmodule

// File: tb/tb_sim_harness_ctrl.sv
// tb_sim_harness_ctrl: randomized check of four sim_harness_ctrl configurations against a run-level model
module tb_sim_harness_ctrl;
  localparam int          RC[4] = '{2, 3, 1, 2};
  localparam int          NC[4] = '{3, 3, 1, 2};
  localparam int          TO[4] = '{0, 30, 20, 0};
  localparam int          SM[4] = '{1, 2, 0, 2};
  localparam int          SP[4] = '{4, 4, 4, 4};
  localparam int          HA[4] = '{1, 0, 1, 1};
  localparam int          CW[4] = '{32, 32, 32, 4};
  localparam logic [15:0] ES[4] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'h1234};
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  hv[4];
  logic        drst[4], rdy[4], fin[4], dn[4], tout[4];
  logic [31:0] cc0, cc1, cc2;
  logic [3:0]  cc3;
  logic [2:0]  hm0, hm1;
  logic [0:0]  hm2;
  logic [1:0]  hm3;
  logic [31:0] gcc[4], ghm[4];
  int          checks = 0, errors = 0;
  int          hold_left[4], run_n[4], outcome[4], hat[4][3];
  logic        fin_m[4];
  logic [2:0]  mask_m[4];
  logic [15:0] lf[4];
  always #5 clk = ~clk;
  sim_harness_ctrl #(.NUM_CORES(3), .RESET_CYCLES(2), .CNT_W(32), .TIMEOUT(0), .STALL_MODE(1),
    .STALL_PERIOD(4), .HALT_ALL(1), .LFSR_SEED(16'hACE1)) u0 (
    .clock(clk), .reset(rstn), .io_halt(hv[0]), .dut_reset(drst[0]), .dut_ready(rdy[0]),
    .finish(fin[0]), .done(dn[0]), .timed_out(tout[0]), .cycle_count(cc0), .halt_mask(hm0));
  sim_harness_ctrl #(.NUM_CORES(3), .RESET_CYCLES(3), .CNT_W(32), .TIMEOUT(30), .STALL_MODE(2),
    .STALL_PERIOD(4), .HALT_ALL(0), .LFSR_SEED(16'h0000)) u1 (
    .clock(clk), .reset(rstn), .io_halt(hv[1]), .dut_reset(drst[1]), .dut_ready(rdy[1]),
    .finish(fin[1]), .done(dn[1]), .timed_out(tout[1]), .cycle_count(cc1), .halt_mask(hm1));
  sim_harness_ctrl #(.NUM_CORES(1), .RESET_CYCLES(1), .CNT_W(32), .TIMEOUT(20), .STALL_MODE(0),
    .STALL_PERIOD(4), .HALT_ALL(1), .LFSR_SEED(16'hACE1)) u2 (
    .clock(clk), .reset(rstn), .io_halt(hv[2][0:0]), .dut_reset(drst[2]), .dut_ready(rdy[2]),
    .finish(fin[2]), .done(dn[2]), .timed_out(tout[2]), .cycle_count(cc2), .halt_mask(hm2));
  sim_harness_ctrl #(.NUM_CORES(2), .RESET_CYCLES(2), .CNT_W(4), .TIMEOUT(0), .STALL_MODE(2),
    .STALL_PERIOD(4), .HALT_ALL(1), .LFSR_SEED(16'h1234)) u3 (
    .clock(clk), .reset(rstn), .io_halt(hv[3][1:0]), .dut_reset(drst[3]), .dut_ready(rdy[3]),
    .finish(fin[3]), .done(dn[3]), .timed_out(tout[3]), .cycle_count(cc3), .halt_mask(hm3));
  assign gcc[0] = cc0;
  assign gcc[1] = cc1;
  assign gcc[2] = cc2;
  assign gcc[3] = {28'd0, cc3};
  assign ghm[0] = {29'd0, hm0};
  assign ghm[1] = {29'd0, hm1};
  assign ghm[2] = {31'd0, hm2};
  assign ghm[3] = {30'd0, hm3};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // predicts the controller after the coming posedge, from the run-level rules
  task automatic step(input int k, input logic r, input logic [2:0] h);
    logic [2:0] m;
    logic       all_hit;
    if (!r) begin
      hold_left[k] = RC[k];
      run_n[k]     = 0;
      outcome[k]   = 0;
      fin_m[k]     = 1'b0;
      mask_m[k]    = '0;
      lf[k]        = ES[k];
    end else if (hold_left[k] > 0) begin
      hold_left[k]--;
      fin_m[k] = 1'b0;
    end else if (outcome[k] == 0) begin
      m       = mask_m[k] | (h & 3'((1 << NC[k]) - 1));
      all_hit = HA[k] != 0 ? (int'(m) == (1 << NC[k]) - 1) : (m != 0);
      run_n[k]++;
      mask_m[k] = m;
      lf[k] = lf[k][0] ? ((lf[k] >> 1) ^ 16'hB400) : (lf[k] >> 1);
      outcome[k] = all_hit ? 1 : (TO[k] != 0 && run_n[k] == TO[k]) ? 2 : 0;
      fin_m[k] = outcome[k] != 0;
    end else begin
      fin_m[k] = 1'b0;
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      logic   running, er;
      longint maxv, ecc;
      running = hold_left[k] == 0 && outcome[k] == 0;
      er = !running ? 1'b0 : SM[k] == 1 ? (run_n[k] % SP[k]) != SP[k] - 1 :
           SM[k] == 2 ? lf[k][0] : 1'b1;
      maxv = (longint'(1) << CW[k]) - 1;
      ecc = run_n[k] > maxv ? maxv : longint'(run_n[k]);
      check($sformatf("dut_reset%0d", k), 32'(drst[k]), 32'(hold_left[k] > 0));
      check($sformatf("dut_ready%0d", k), 32'(rdy[k]), 32'(er));
      check($sformatf("finish%0d", k), 32'(fin[k]), 32'(fin_m[k]));
      check($sformatf("done%0d", k), 32'(dn[k]), 32'(outcome[k] == 1));
      check($sformatf("timed_out%0d", k), 32'(tout[k]), 32'(outcome[k] == 2));
      check($sformatf("cycle_count%0d", k), gcc[k], 32'(ecc));
      check($sformatf("halt_mask%0d", k), ghm[k], 32'(mask_m[k]));
    end
  endtask
  initial begin
    for (int k = 0; k < 4; k++) hv[k] = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 4; k++) step(k, 1'b0, 3'b000);
    for (int t = 0; t < 8; t++) begin
      int mode;
      mode = t % 4;
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 3; c++)
          hat[k][c] = mode == 0 ? int'($urandom_range(1, 25)) :
                      mode == 1 ? int'($urandom_range(1, 40)) :
                      mode == 2 ? 1000 : (k == 1 ? 30 : k == 2 ? 20 : 1);
      for (int cyc = 0; cyc < 70; cyc++) begin
        logic r;
        @(negedge clk);
        check_all();
        r = !(cyc == 0 || (t >= 4 && cyc == 12));
        rstn = r;
        for (int k = 0; k < 4; k++) begin
          hv[k] = '0;
          for (int c = 0; c < NC[k]; c++)
            hv[k][c] = mode == 1 ? (run_n[k] + 1 >= hat[k][c]) : (run_n[k] + 1 == hat[k][c]);
          step(k, r, hv[k]);
        end
      end
    end
    @(negedge clk);
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
